branch_predictor_bht: RTL and testbench
=======================================

# branch_predictor_bht

Parametrised dynamic branch predictor for the 5-stage RV32 core, replacing the fixed-output predictor stub between Fetch and Execute. Fetch presents its PC every cycle and receives a same-cycle taken/target prediction from a tagged branch target buffer (BTB) combined with a pattern history table (PHT) of 2-bit saturating counters. Execute returns resolved outcomes to train the tables. The block also keeps a global history register (gshare mode) and prediction/misprediction statistics counters.

## Interface
- ENTRIES, 64: BTB and PHT depth; power of two, 4..1024; IDX = log2(ENTRIES).
- TAG_BITS, 8: BTB tag width; tag = PC[2+IDX+TAG_BITS-1 : 2+IDX].
- HISTORY_BITS, 0: 0 = bimodal; 1..IDX = gshare using this many global history bits.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- lookupValid  in  1  Fetch PC is valid this cycle
- lookupPC  in  32  Fetch PC (instructionAddress)
- branchPredictValid  out  1  predicted taken; redirect Fetch
- branchPredictData  out  32  predicted target
- predictHistory  out  max(HISTORY_BITS,1)  GHR snapshot at lookup; carried down the pipe; 0 when HISTORY_BITS=0
- updateValid  in  1  resolved control-flow instruction from Execute
- updatePC  in  32  its PC
- updateConditional  in  1  1 = Bxx, 0 = JAL/JALR
- updateTaken  in  1  actual direction; unconditional is always 1
- updateTarget  in  32  actual target
- updateHistory  in  max(HISTORY_BITS,1)  predictHistory returned with the instruction
- updateMispredict  in  1  Execute redirected; qualified by updateValid
- predictCount  out  32  updates received
- mispredictCount  out  32  updates with updateMispredict

## Operation
- BTB entry: valid, tag, target[31:2], uncond bit. BTB index = PC[2+IDX-1:2].
- PHT index: bimodal = PC[2+IDX-1:2]; gshare = PC[2+IDX-1:2] XOR zero-extended history, where history is the GHR for lookup and updateHistory for update.
- Prediction: hit = lookupValid & valid & tag match; branchPredictValid = hit & (uncond | PHT[idx][1]); branchPredictData = {target,2'b00} when valid, else 0.
- Update, when updateValid:
  - Conditional: PHT counter increments if taken, decrements if not; saturates at 2'b11 and 2'b00.
  - Taken: BTB entry written with valid=1, new tag, target, uncond=~updateConditional. Replaces any existing occupant.
  - Not taken: BTB entry untouched.
  - Conditional with HISTORY_BITS>0: GHR <= {GHR[HISTORY_BITS-2:0], updateTaken}.
  - predictCount += 1; mispredictCount += updateMispredict. Both wrap modulo 2^32.
- updateTarget[1:0] ignored.
- Reset clears all BTB valid bits, sets all PHT counters to 2'b01 (weakly not-taken), and clears GHR and both statistics counters.

## Timing
- Lookup is combinational from registered state: zero-cycle latency.
- Updates commit at the rising edge. A lookup in the same cycle as an update to the same index sees the pre-update value; there is no bypass.
- Lookup and update of different indices in the same cycle are independent.
- Reset mid-operation: tables are cleared at that edge and any update in the reset cycle is discarded. While reset is high, branchPredictValid = 0.
- Update with lookupValid=0 still trains the tables.
- Outputs after reset: branchPredictValid=0, branchPredictData=0, predictHistory=0, counters=0.

## Test plan
- Reset, then lookup PC=0x100 -> branchPredictValid=0, branchPredictData=0, predictCount=0.
- Bimodal: two taken conditional updates at 0x100 with target 0x200, then lookup 0x100 -> predict taken, target 0x200. Three not-taken updates -> valid=0; the counter saturates at 00 and a further not-taken update stays at 00.
- JAL update at 0x40 with target 0x80, then lookup 0x40 -> predict taken on the next cycle regardless of PHT state. Same-cycle lookup+update -> branchPredictValid=0.
- ENTRIES=64, TAG_BITS=8: train 0x100 taken, then train 0x200 taken (same index, different tag) -> lookup 0x100 misses, lookup 0x200 hits.
- HISTORY_BITS=4: alternating T/N/T/N outcomes at 0x300 with history returned -> after warm-up, predictions match the pattern at 100%; GHR after reset and updates T,T,N = 4'b0110.
- 2^32 updates (counter forced near wrap: 0xFFFFFFFF + 1) -> predictCount=0; mispredictCount increments only when updateValid & updateMispredict.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: tagged BTB plus a PHT of 2-bit saturating
// counters, indexed either bimodally or gshare-style with a global history
// register. Lookup is combinational from registered state; training from
// Execute commits at the rising edge with no same-cycle bypass.
module branch_predictor_bht #(
   parameter int unsigned ENTRIES      = 64,
   parameter int unsigned TAG_BITS     = 8,
   parameter int unsigned HISTORY_BITS = 0
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        lookupValid,
   input  logic [31:0]                                 lookupPC,
   output logic                                        branchPredictValid,
   output logic [31:0]                                 branchPredictData,
   output logic [((HISTORY_BITS > 0) ? HISTORY_BITS : 1)-1:0] predictHistory,
   input  logic                                        updateValid,
   input  logic [31:0]                                 updatePC,
   input  logic                                        updateConditional,
   input  logic                                        updateTaken,
   input  logic [31:0]                                 updateTarget,
   input  logic [((HISTORY_BITS > 0) ? HISTORY_BITS : 1)-1:0] updateHistory,
   input  logic                                        updateMispredict,
   output logic [31:0]                                 predictCount,
   output logic [31:0]                                 mispredictCount
);

   localparam int unsigned IDX = $clog2(ENTRIES);
   localparam int unsigned HW  = (HISTORY_BITS > 0) ? HISTORY_BITS : 1;

   // Table storage
   logic                btbValid  [ENTRIES];
   logic [TAG_BITS-1:0] btbTag    [ENTRIES];
   logic [29:0]         btbTarget [ENTRIES];
   logic                btbUncond [ENTRIES];
   logic [1:0]          pht       [ENTRIES];
   logic [HW-1:0]       ghr;

   // Derived indices and tags
   logic [IDX-1:0]      lookIdx;
   logic [IDX-1:0]      updIdx;
   logic [IDX-1:0]      lookPhtIdx;
   logic [IDX-1:0]      updPhtIdx;
   logic [TAG_BITS-1:0] lookTag;
   logic [TAG_BITS-1:0] updTag;
   logic [1:0]          phtNext;
   logic                lookHit;
   logic                unusedBits;

   // Slice BTB index and tag fields out of both PCs
   always_comb begin
      lookIdx = lookupPC[2+IDX-1:2];
      updIdx  = updatePC[2+IDX-1:2];
      lookTag = lookupPC[2+IDX+TAG_BITS-1:2+IDX];
      updTag  = updatePC[2+IDX+TAG_BITS-1:2+IDX];
   end

   // Bits that play no part in indexing, tagging or target storage
   always_comb begin
      unusedBits = ^{lookupPC, updatePC, updateTarget[1:0], updateHistory};
   end

   generate
      if (HISTORY_BITS == 0) begin : gBimodal
         // Bimodal: PHT shares the BTB index; no global history kept
         always_comb begin
            lookPhtIdx = lookIdx;
            updPhtIdx  = updIdx;
            ghr        = '0;
         end
      end else begin : gGshare
         // Gshare: fold zero-extended history into the PC index
         always_comb begin
            lookPhtIdx = lookIdx ^ IDX'(ghr);
            updPhtIdx  = updIdx ^ IDX'(updateHistory);
         end

         // Shift resolved conditional outcomes into the global history
         always_ff @(posedge clock) begin
            if (reset) begin
               ghr <= '0;
            end else if (updateValid && updateConditional) begin
               // Truncating cast drops the oldest bit; also covers a 1-bit history
               ghr <= HW'({ghr, updateTaken});
            end
         end
      end
   endgenerate

   // Saturating next value for the PHT counter being trained
   always_comb begin
      phtNext = pht[updPhtIdx];
      if (updateTaken) begin
         if (phtNext != 2'b11) begin
            phtNext = phtNext + 2'b01;
         end
      end else if (phtNext != 2'b00) begin
         phtNext = phtNext - 2'b01;
      end
   end

   // Same-cycle prediction from registered table contents
   always_comb begin
      lookHit            = lookupValid & btbValid[lookIdx] & (btbTag[lookIdx] == lookTag);
      branchPredictValid = ~reset & lookHit & (btbUncond[lookIdx] | pht[lookPhtIdx][1]);
      branchPredictData  = branchPredictValid ? {btbTarget[lookIdx], 2'b00} : '0;
      predictHistory     = ghr;
   end

   // Train BTB and PHT from resolved branches; reset invalidates everything
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            btbValid[IDX'(i)] <= 1'b0;
            pht[IDX'(i)]      <= 2'b01;
         end
      end else if (updateValid) begin
         if (updateTaken) begin
            btbValid[updIdx]  <= 1'b1;
            btbTag[updIdx]    <= updTag;
            btbTarget[updIdx] <= updateTarget[31:2];
            btbUncond[updIdx] <= ~updateConditional;
         end
         if (updateConditional) begin
            pht[updPhtIdx] <= phtNext;
         end
      end
   end

   // Prediction and misprediction statistics, wrapping modulo 2^32
   always_ff @(posedge clock) begin
      if (reset) begin
         predictCount    <= '0;
         mispredictCount <= '0;
      end else if (updateValid) begin
         predictCount <= predictCount + 32'd1;
         if (updateMispredict) begin
            mispredictCount <= mispredictCount + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: a bimodal and a 4-bit gshare instance share
// stimulus; a behavioural model predicts every output each cycle, and directed
// sequences pin the model with hand-computed expectations.
module tb_branch_predictor_bht;

   logic        clock = 1'b0;
   logic        reset;
   logic        lookupValid;
   logic [31:0] lookupPC;
   logic        updateValid;
   logic [31:0] updatePC;
   logic        updateConditional;
   logic        updateTaken;
   logic [31:0] updateTarget;
   logic        updateMispredict;
   logic [3:0]  updHistG;
   logic [0:0]  updHistB;

   logic        pvB, pvG;
   logic [31:0] pdB, pdG;
   logic [0:0]  phB;
   logic [3:0]  phG;
   logic [31:0] pcB, pcG, mcB, mcG;

   int unsigned nVec  = 0;
   int unsigned nFail = 0;
   bit          modelReady = 1'b0;

   // Behavioural model state
   bit          mValid  [64];
   int unsigned mTag    [64];
   logic [31:0] mTarget [64];
   bit          mUncond [64];
   int          mPht    [2][64];
   int unsigned mGhr;
   logic [31:0] mPred;
   logic [31:0] mMisp;

   logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h300, 32'h40,
                             32'h44, 32'h104, 32'h1100, 32'h2300};

   always #5 clock = ~clock;

   branch_predictor_bht #(.ENTRIES(64), .TAG_BITS(8), .HISTORY_BITS(0)) dutB (
      .clock(clock), .reset(reset), .lookupValid(lookupValid), .lookupPC(lookupPC),
      .branchPredictValid(pvB), .branchPredictData(pdB), .predictHistory(phB),
      .updateValid(updateValid), .updatePC(updatePC), .updateConditional(updateConditional),
      .updateTaken(updateTaken), .updateTarget(updateTarget), .updateHistory(updHistB),
      .updateMispredict(updateMispredict), .predictCount(pcB), .mispredictCount(mcB)
   );

   branch_predictor_bht #(.ENTRIES(64), .TAG_BITS(8), .HISTORY_BITS(4)) dutG (
      .clock(clock), .reset(reset), .lookupValid(lookupValid), .lookupPC(lookupPC),
      .branchPredictValid(pvG), .branchPredictData(pdG), .predictHistory(phG),
      .updateValid(updateValid), .updatePC(updatePC), .updateConditional(updateConditional),
      .updateTaken(updateTaken), .updateTarget(updateTarget), .updateHistory(updHistG),
      .updateMispredict(updateMispredict), .predictCount(pcG), .mispredictCount(mcG)
   );

   function automatic int unsigned btbIdx(logic [31:0] pc);
      return (pc / 4) % 64;
   endfunction

   function automatic int unsigned tagOf(logic [31:0] pc);
      return (pc / 256) % 256;
   endfunction

   function automatic int unsigned phtIdx(logic [31:0] pc, int unsigned hist, int k);
      if (k == 0) return btbIdx(pc);
      return btbIdx(pc) ^ (hist % 16);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareOne(int k, logic pv, logic [31:0] pd, logic [31:0] ph,
                             logic [31:0] pc, logic [31:0] mc);
      int unsigned i;
      int unsigned pi;
      bit          expV;
      logic [31:0] expD;
      i    = btbIdx(lookupPC);
      pi   = phtIdx(lookupPC, mGhr, k);
      expV = !reset && lookupValid && mValid[i] && (mTag[i] == tagOf(lookupPC)) &&
             (mUncond[i] || mPht[k][pi] >= 2);
      expD = expV ? mTarget[i] : 32'd0;
      check(k == 0 ? "model_b_valid" : "model_g_valid", {31'd0, pv}, {31'd0, expV});
      check(k == 0 ? "model_b_data"  : "model_g_data",  pd, expD);
      check(k == 0 ? "model_b_hist"  : "model_g_hist",  ph, (k == 0) ? 32'd0 : mGhr);
      check(k == 0 ? "model_b_pcnt"  : "model_g_pcnt",  pc, mPred);
      check(k == 0 ? "model_b_mcnt"  : "model_g_mcnt",  mc, mMisp);
   endtask

   // Compare both instances against the model away from the active edge
   always @(negedge clock) begin
      if (modelReady) begin
         compareOne(0, pvB, pdB, 32'(phB), pcB, mcB);
         compareOne(1, pvG, pdG, 32'(phG), pcG, mcG);
      end
   end

   // Advance the model with the inputs seen at the rising edge
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) begin
            mValid[i]  = 1'b0;
            mPht[0][i] = 1;
            mPht[1][i] = 1;
         end
         mGhr       = 0;
         mPred      = 0;
         mMisp      = 0;
         modelReady = 1'b1;
      end else if (modelReady && updateValid) begin
         for (int k = 0; k < 2; k++) begin
            int unsigned pi;
            pi = phtIdx(updatePC, 32'(updHistG), k);
            if (updateConditional) begin
               if (updateTaken) mPht[k][pi] = (mPht[k][pi] == 3) ? 3 : mPht[k][pi] + 1;
               else             mPht[k][pi] = (mPht[k][pi] == 0) ? 0 : mPht[k][pi] - 1;
            end
         end
         if (updateTaken) begin
            mValid[btbIdx(updatePC)]  = 1'b1;
            mTag[btbIdx(updatePC)]    = tagOf(updatePC);
            mTarget[btbIdx(updatePC)] = updateTarget & 32'hFFFF_FFFC;
            mUncond[btbIdx(updatePC)] = !updateConditional;
         end
         if (updateConditional) mGhr = ((mGhr * 2) + (updateTaken ? 1 : 0)) % 16;
         mPred = mPred + 32'd1;
         if (updateMispredict) mMisp = mMisp + 32'd1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic doUpdate(logic [31:0] pc, bit cond, bit taken, logic [31:0] tgt, bit misp);
      updateValid       = 1'b1;
      updatePC          = pc;
      updateConditional = cond;
      updateTaken       = taken;
      updateTarget      = tgt;
      updateMispredict  = misp;
      updHistG          = 4'(mGhr);
      updHistB          = 1'b0;
      tick();
      updateValid       = 1'b0;
      updateMispredict  = 1'b0;
   endtask

   task automatic lookExpect(string name, int k, logic [31:0] pc, bit expV, logic [31:0] expD);
      lookupValid = 1'b1;
      lookupPC    = pc;
      #1;
      if (k == 0) begin
         check({name, "_valid"}, {31'd0, pvB}, {31'd0, expV});
         check({name, "_data"}, pdB, expD);
      end else begin
         check({name, "_valid"}, {31'd0, pvG}, {31'd0, expV});
         check({name, "_data"}, pdG, expD);
      end
      tick();
      lookupValid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; lookupValid = 1'b0; lookupPC = '0;
      updateValid = 1'b0; updatePC = '0; updateConditional = 1'b0; updateTaken = 1'b0;
      updateTarget = '0; updateMispredict = 1'b0; updHistG = '0; updHistB = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      lookExpect("rst_look", 0, 32'h100, 1'b0, 32'h0);
      check("rst_pcnt", pcB, 32'd0);
      check("rst_ghr", 32'(phG), 32'd0);

      // Bimodal train/untrain with saturation at 00
      doUpdate(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
      doUpdate(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
      lookExpect("bim_taken", 0, 32'h100, 1'b1, 32'h200);
      repeat (3) doUpdate(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
      lookExpect("bim_nt", 0, 32'h100, 1'b0, 32'h0);
      doUpdate(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
      doUpdate(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
      lookExpect("bim_sat0", 0, 32'h100, 1'b0, 32'h0);
      doUpdate(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
      lookExpect("bim_recover", 0, 32'h100, 1'b1, 32'h200);
      check("bim_pcnt", pcB, 32'd8);

      // Unconditional jumps, same-cycle lookup sees pre-update state
      doUpdate(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
      lookExpect("jal", 0, 32'h40, 1'b1, 32'h80);
      lookExpect("jal_g", 1, 32'h40, 1'b1, 32'h80);
      updateValid = 1'b1; updatePC = 32'h44; updateConditional = 1'b0;
      updateTaken = 1'b1; updateTarget = 32'h93; updHistG = 4'(mGhr);
      lookupValid = 1'b1; lookupPC = 32'h44;
      #1;
      check("jal_same_cycle", {31'd0, pvB}, 32'd0);
      tick();
      updateValid = 1'b0; lookupValid = 1'b0;
      lookExpect("jal_next", 0, 32'h44, 1'b1, 32'h90);

      // Tag aliasing on a shared index
      doReset();
      doUpdate(32'h100, 1'b1, 1'b1, 32'h500, 1'b0);
      doUpdate(32'h100, 1'b1, 1'b1, 32'h500, 1'b0);
      doUpdate(32'h200, 1'b1, 1'b1, 32'h600, 1'b0);
      lookExpect("alias_old", 0, 32'h100, 1'b0, 32'h0);
      lookExpect("alias_new", 0, 32'h200, 1'b1, 32'h600);

      // Global history after T,T,N
      doReset();
      doUpdate(32'h300, 1'b1, 1'b1, 32'h380, 1'b0);
      doUpdate(32'h300, 1'b1, 1'b1, 32'h380, 1'b0);
      doUpdate(32'h300, 1'b1, 1'b0, 32'h380, 1'b0);
      check("ghr_ttn", 32'(phG), 32'h6);
      check("ghr_bimodal", 32'(phB), 32'd0);

      // Gshare learns a strict alternation
      doReset();
      for (int i = 0; i < 16; i++) begin
         bit t;
         t = (i % 2) == 0;
         if (i >= 8) begin
            lookExpect("gshare_alt", 1, 32'h300, t, t ? 32'h380 : 32'h0);
         end else begin
            lookupValid = 1'b1; lookupPC = 32'h300;
            tick();
            lookupValid = 1'b0;
         end
         doUpdate(32'h300, 1'b1, t, 32'h380, 1'b0);
      end

      // Statistics: mispredict counts only qualified updates
      doReset();
      doUpdate(32'h500, 1'b1, 1'b0, 32'h0, 1'b1);
      doUpdate(32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
      doUpdate(32'h500, 1'b1, 1'b0, 32'h0, 1'b1);
      updateMispredict = 1'b1;
      tick();
      updateMispredict = 1'b0;
      check("stat_pcnt", pcG, 32'd3);
      check("stat_mcnt", mcG, 32'd2);

      // Reset mid-operation discards the concurrent update
      repeat (3) doUpdate(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
      lookExpect("pre_reset", 0, 32'h100, 1'b1, 32'h200);
      reset = 1'b1; lookupValid = 1'b1; lookupPC = 32'h100;
      updateValid = 1'b1; updatePC = 32'h40; updateConditional = 1'b0;
      updateTaken = 1'b1; updateTarget = 32'h80;
      #1;
      check("reset_hold_valid", {31'd0, pvB}, 32'd0);
      tick();
      reset = 1'b0; updateValid = 1'b0; lookupValid = 1'b0;
      lookExpect("post_reset_100", 0, 32'h100, 1'b0, 32'h0);
      lookExpect("post_reset_jal", 0, 32'h40, 1'b0, 32'h0);
      check("post_reset_pcnt", pcB, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset             = ($urandom_range(0, 199) == 0);
         lookupValid       = 1'($urandom);
         lookupPC          = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
         updateValid       = 1'($urandom);
         updatePC          = pool[$urandom_range(0, 7)];
         updateConditional = 1'($urandom);
         updateTaken       = updateConditional ? 1'($urandom) : 1'b1;
         updateTarget      = $urandom;
         updHistG          = ($urandom_range(0, 1) == 0) ? 4'(mGhr) : 4'($urandom);
         updHistB          = 1'($urandom);
         updateMispredict  = 1'($urandom);
         tick();
      end
      reset = 1'b0; lookupValid = 1'b0; updateValid = 1'b0; updateMispredict = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
